soc_boot_seq: RTL and testbench
===============================

SOC_BOOT_SEQ -- requirements
Module: soc_boot_seq

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles soc_rstn_o is held low after rstn_glob_i is released.
REQ-002 SHALL have parameter STRAP_SAMPLES, default 4: consecutive identical synchronized bootsel samples required to accept the strap.
REQ-003 SHALL have parameter STRAP_TIMEOUT, default 64: maximum cycles spent in STRAP before a forced latch.
REQ-004 SHALL have parameter FETCH_DELAY, default 8: cycles between soc_rstn_o release and fc_fetch_en_valid_o assertion.
REQ-005 ref_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rstn_glob_i  in  1  reset, synchronous, active-low.
REQ-007 bootsel_pad_i  in  2  raw boot-select strap from pads, asynchronous.
REQ-008 fetch_en_pad_i  in  1  raw fetch-enable pad, asynchronous.
REQ-009 soc_rstn_o  out  1  SoC-domain reset, active-low, feeds the SoC domain's global reset.
REQ-010 bootsel_o  out  2  latched boot select, feeds the SoC domain's bootsel input.
REQ-011 fc_fetch_en_valid_o  out  1  fetch-enable override valid for the fabric controller.
REQ-012 fc_fetch_en_o  out  1  fabric controller fetch enable.
REQ-013 strap_err_o  out  1  strap never stable; sticky until reset.
REQ-014 boot_done_o  out  1  sequence complete (state RUN).

Function
REQ-015 Both pad inputs SHALL pass through a 2-flop synchronizer (reset value 0) before any use.
REQ-016 FSM states SHALL be HOLD, STRAP, RELEASE, RUN; only one cycle counter, cleared on every state transition.
REQ-017 HOLD SHALL last exactly RST_HOLD_CYCLES cycles, then go to STRAP.
REQ-018 STRAP SHALL count consecutive cycles with unchanged synchronized bootsel; a change reloads the count to 1; on reaching STRAP_SAMPLES, latch the value into bootsel_o and go to RELEASE.
REQ-019 If STRAP_TIMEOUT cycles elapse in STRAP without acceptance, STRAP SHALL latch the current synchronized value, set strap_err_o, and go to RELEASE.
REQ-020 Acceptance and timeout occurring in the same cycle SHALL count as acceptance (strap_err_o stays 0).
REQ-021 soc_rstn_o SHALL be a registered output, 1 exactly while in RELEASE or RUN.
REQ-022 RELEASE SHALL last FETCH_DELAY cycles, then go to RUN.
REQ-023 In RUN, fc_fetch_en_valid_o and boot_done_o SHALL be 1; RUN is terminal until reset.
REQ-024 bootsel_o SHALL be stable from the STRAP exit until reset; pad changes after STRAP SHALL be ignored.
REQ-025 Counters SHALL saturate and never wrap; no parameter value of 0 is supported (minimum 1).

Reset
REQ-026 rstn_glob_i low at a rising edge SHALL, regardless of state (including mid-sequence), force HOLD, clear counters and synchronizers, and set soc_rstn_o=0, bootsel_o=0, fc_fetch_en_valid_o=0, fc_fetch_en_o=0, strap_err_o=0, boot_done_o=0.

Configuration
REQ-027 Macro BOOT_SEQ_AUTOFETCH_EN defined: fc_fetch_en_o SHALL be 1 whenever in RUN, independent of fetch_en_pad_i.
REQ-028 Macro BOOT_SEQ_AUTOFETCH_EN undefined: in RUN, fc_fetch_en_o SHALL equal the synchronized fetch_en_pad_i; 0 elsewhere.

Verification
REQ-029 Defaults, bootsel_pad_i=2'b01 stable, release reset -> soc_rstn_o rises 20 (+1 register) cycles after release; bootsel_o=2'b01; fc_fetch_en_valid_o rises 8 cycles later; strap_err_o=0.
REQ-030 Bootsel toggles every 2 cycles throughout STRAP -> forced latch after 64 cycles in STRAP, strap_err_o=1, sequence continues to RUN.
REQ-031 Bootsel glitches once to 2'b10 on the third STRAP cycle, then returns to 2'b11 -> acceptance delayed, bootsel_o=2'b11, strap_err_o=0.
REQ-032 rstn_glob_i pulsed low for 1 cycle during RELEASE -> all outputs return to reset values next edge; full sequence restarts from HOLD.
REQ-033 Without BOOT_SEQ_AUTOFETCH_EN, fetch_en_pad_i=0 then 1 during RUN -> fc_fetch_en_o rises exactly 2 cycles after the pad edge; with macro, fc_fetch_en_o=1 on RUN entry with pad held 0.
REQ-034 Bootsel pad changed to 2'b00 during RUN -> bootsel_o unchanged.

Source files
------------

// File: rtl/soc_boot_seq.sv
// SoC boot sequencer: reset hold, boot-strap sampling, staged release, run.
// Define BOOT_SEQ_AUTOFETCH_EN to force fc_fetch_en_o high in RUN.
module soc_boot_seq #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int STRAP_SAMPLES   = 4,
  parameter int STRAP_TIMEOUT   = 64,
  parameter int FETCH_DELAY     = 8
) (
  input  logic       ref_clk_i,
  input  logic       rstn_glob_i,
  input  logic [1:0] bootsel_pad_i,
  input  logic       fetch_en_pad_i,
  output logic       soc_rstn_o,
  output logic [1:0] bootsel_o,
  output logic       fc_fetch_en_valid_o,
  output logic       fc_fetch_en_o,
  output logic       strap_err_o,
  output logic       boot_done_o
);

  localparam int MAXA = (RST_HOLD_CYCLES > STRAP_TIMEOUT) ?
                        RST_HOLD_CYCLES : STRAP_TIMEOUT;
  localparam int MAXP = (MAXA > FETCH_DELAY) ? MAXA : FETCH_DELAY;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int SW   = $clog2(STRAP_SAMPLES + 1);

  typedef enum logic [1:0] {
    HOLD,
    STRAP,
    RELEASE,
    RUN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [SW-1:0]   samp, samp_n, samp_inc, samp_new;
  logic [1:0]      samp_val, samp_val_n;
  logic [1:0]      bs_s1, bs_s2;
  logic            fe_s1, fe_s2;
  logic [1:0]      bootsel_q, bootsel_n;
  logic            err_q, err_n;
  logic            rst_q, run_q;

  always_ff @(posedge ref_clk_i) begin
    if (!rstn_glob_i) begin
      state     <= HOLD;
      cnt       <= '0;
      samp      <= '0;
      samp_val  <= '0;
      bs_s1     <= '0;
      bs_s2     <= '0;
      fe_s1     <= 1'b0;
      fe_s2     <= 1'b0;
      bootsel_q <= '0;
      err_q     <= 1'b0;
      rst_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      samp      <= samp_n;
      samp_val  <= samp_val_n;
      bs_s1     <= bootsel_pad_i;
      bs_s2     <= bs_s1;
      fe_s1     <= fetch_en_pad_i;
      fe_s2     <= fe_s1;
      bootsel_q <= bootsel_n;
      err_q     <= err_n;
      rst_q     <= (state == RELEASE) || (state == RUN);
      run_q     <= (state == RUN);
    end
  end

  // Saturating increments keep every counter from wrapping.
  assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign samp_inc = (samp >= SW'(STRAP_SAMPLES)) ? samp : samp + 1'b1;
  assign samp_new = ((samp == '0) || (bs_s2 != samp_val)) ?
                    SW'(1) : samp_inc;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt_inc;
    samp_n     = samp;
    samp_val_n = samp_val;
    bootsel_n  = bootsel_q;
    err_n      = err_q;
    unique case (state)
      HOLD: begin
        if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
          state_n = STRAP;
          cnt_n   = '0;
          samp_n  = '0;
        end
      end
      STRAP: begin
        samp_n     = samp_new;
        samp_val_n = bs_s2;
        // Acceptance wins over a coincident timeout.
        if (samp_new >= SW'(STRAP_SAMPLES)) begin
          state_n   = RELEASE;
          cnt_n     = '0;
          bootsel_n = bs_s2;
        end else if (cnt == CW'(STRAP_TIMEOUT - 1)) begin
          state_n   = RELEASE;
          cnt_n     = '0;
          bootsel_n = bs_s2;
          err_n     = 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == CW'(FETCH_DELAY - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  assign soc_rstn_o          = rst_q;
  assign bootsel_o           = bootsel_q;
  assign fc_fetch_en_valid_o = run_q;
  assign strap_err_o         = err_q;
  assign boot_done_o         = run_q;

`ifdef BOOT_SEQ_AUTOFETCH_EN
  assign fc_fetch_en_o = run_q;
`else
  assign fc_fetch_en_o = run_q & fe_s2;
`endif

endmodule

// File: tb/tb_soc_boot_seq.sv
// Directed bench for soc_boot_seq: vector table plus corner sequences.
module tb_soc_boot_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] bs;
  logic       fe;
  logic       soc_rstn;
  logic [1:0] bsel;
  logic       vld;
  logic       fe_o;
  logic       err;
  logic       done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  soc_boot_seq dut (
    .ref_clk_i           (clk),
    .rstn_glob_i         (rstn),
    .bootsel_pad_i       (bs),
    .fetch_en_pad_i      (fe),
    .soc_rstn_o          (soc_rstn),
    .bootsel_o           (bsel),
    .fc_fetch_en_valid_o (vld),
    .fc_fetch_en_o       (fe_o),
    .strap_err_o         (err),
    .boot_done_o         (done)
  );

  typedef struct {
    string      name;
    logic       rstn;
    logic [1:0] bs;
    logic       fe;
    int         n;
    logic       soc;
    logic [1:0] bsel;
    logic       vld;
    logic       fe_o;
    logic       err;
    logic       done;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    logic exp_fe;
    rstn = 1'b0;
    bs   = 2'b01;
    fe   = 1'b0;

    // name rstn bs fe n | soc bsel vld fe_o err done (edge after release)
    tbl[0]  = '{"reset",     0, 2'b01, 0,  3, 0, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{"e19",       1, 2'b01, 0, 19, 0, 2'b00, 0, 0, 0, 0};
    tbl[2]  = '{"e20_latch", 1, 2'b01, 0,  1, 0, 2'b01, 0, 0, 0, 0};
    tbl[3]  = '{"e21_rstn",  1, 2'b01, 0,  1, 1, 2'b01, 0, 0, 0, 0};
    tbl[4]  = '{"e28",       1, 2'b01, 0,  7, 1, 2'b01, 0, 0, 0, 0};
    tbl[5]  = '{"e29_run",   1, 2'b01, 0,  1, 1, 2'b01, 1, 0, 0, 1};
    tbl[6]  = '{"fe_pad+1",  1, 2'b01, 1,  1, 1, 2'b01, 1, 0, 0, 1};
    tbl[7]  = '{"fe_pad+2",  1, 2'b01, 1,  1, 1, 2'b01, 1, 1, 0, 1};
    tbl[8]  = '{"bs_run",    1, 2'b00, 1,  5, 1, 2'b01, 1, 1, 0, 1};
    tbl[9]  = '{"fe_low",    1, 2'b00, 0,  2, 1, 2'b01, 1, 0, 0, 1};
    tbl[10] = '{"hold_run",  1, 2'b11, 0, 20, 1, 2'b01, 1, 0, 0, 1};

    foreach (tbl[i]) begin
      rstn = tbl[i].rstn;
      bs   = tbl[i].bs;
      fe   = tbl[i].fe;
      step(tbl[i].n);
`ifdef BOOT_SEQ_AUTOFETCH_EN
      exp_fe = tbl[i].done;
`else
      exp_fe = tbl[i].fe_o;
`endif
      chk({tbl[i].name, ".soc"},  int'(soc_rstn), int'(tbl[i].soc));
      chk({tbl[i].name, ".bsel"}, int'(bsel),     int'(tbl[i].bsel));
      chk({tbl[i].name, ".vld"},  int'(vld),      int'(tbl[i].vld));
      chk({tbl[i].name, ".fe"},   int'(fe_o),     int'(exp_fe));
      chk({tbl[i].name, ".err"},  int'(err),      int'(tbl[i].err));
      chk({tbl[i].name, ".done"}, int'(done),     int'(tbl[i].done));
    end

    // Strap toggling every 2 cycles: forced latch at timeout.
    bs = 2'b01;
    fe = 1'b0;
    do_reset();
    for (int e = 1; e <= 89; e++) begin
      step(1);
      if (e == 79) chk("tog.err79", int'(err), 0);
      if (e == 80) chk("tog.err80", int'(err), 1);
      if (e == 80) chk("tog.soc80", int'(soc_rstn), 0);
      if (e == 81) chk("tog.soc81", int'(soc_rstn), 1);
      if (e == 88) chk("tog.vld88", int'(vld), 0);
      if (e == 89) chk("tog.vld89", int'(vld), 1);
      if (e == 89) chk("tog.done", int'(done), 1);
      if (e == 89) chk("tog.err89", int'(err), 1);
      bs = ((e / 2) % 2 == 1) ? 2'b10 : 2'b01;
    end

    // Single glitch to 10 seen on the third strap cycle.
    bs = 2'b11;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      step(1);
      if (e == 20) chk("gl.bsel20", int'(bsel), 0);
      if (e == 22) chk("gl.bsel22", int'(bsel), 0);
      if (e == 23) chk("gl.bsel23", int'(bsel), 3);
      if (e == 23) chk("gl.soc23", int'(soc_rstn), 0);
      if (e == 24) chk("gl.soc24", int'(soc_rstn), 1);
      if (e == 24) chk("gl.err", int'(err), 0);
      if (e == 16) bs = 2'b10;
      if (e == 17) bs = 2'b11;
    end

    // One-cycle reset pulse during RELEASE restarts the sequence.
    bs = 2'b01;
    do_reset();
    step(22);
    chk("rp.soc_pre", int'(soc_rstn), 1);
    chk("rp.bsel_pre", int'(bsel), 1);
    rstn = 1'b0;
    bs   = 2'b10;
    step(1);
    chk("rp.soc", int'(soc_rstn), 0);
    chk("rp.bsel", int'(bsel), 0);
    chk("rp.vld", int'(vld), 0);
    chk("rp.done", int'(done), 0);
    rstn = 1'b1;
    step(20);
    chk("rp.bsel20", int'(bsel), 2);
    chk("rp.soc20", int'(soc_rstn), 0);
    step(1);
    chk("rp.soc21", int'(soc_rstn), 1);
    step(7);
    chk("rp.vld28", int'(vld), 0);
    step(1);
    chk("rp.vld29", int'(vld), 1);
    chk("rp.err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
